branch_resolver: RTL and testbench

//  Tracks every fetched instruction's branch prediction from fetch (F) to execute (E) in an in-order queue.
//  At E it compares the prediction with the resolved outcome (BranchE & ZeroE, PCTargetE).
//  On a mismatch it produces the one-cycle resetBranch / SavedPC redirect consumed by the branch predictor's next-PC mux.
//  It also returns the E-stage instruction PC (ResolvedPC), which drives the predictor's training PC port.

---
 rtl/branch_resolver_pkg.sv | 33 +++
 rtl/branch_resolver_fifo.sv | 71 +++++++
 rtl/branch_resolver.sv | 134 +++++++++++++
 tb/tb_branch_resolver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared constants and the redirect classifier for the branch resolver.
// A queue entry packs {PC, PCPlus4, PredTaken, PredNextPC} from MSB to LSB.
package branch_resolver_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int BRQ_DEPTH   = 4;

  // Entry field offsets (LSB position of each field)
  localparam int BRQ_NPC     = 0;
  localparam int BRQ_PRED    = WORD_SIZE;
  localparam int BRQ_PC4     = WORD_SIZE + 1;
  localparam int BRQ_PC      = 2 * WORD_SIZE + 1;
  localparam int BRQ_ENTRY_W = 3 * WORD_SIZE + 1;

  typedef enum logic [1:0] {
    REDIR_NONE     = 2'd0,
    REDIR_FALLTHRU = 2'd1,
    REDIR_TARGET   = 2'd2
  } redir_e;

  // A taken prediction with the wrong target is also a mispredict.
  function automatic redir_e classify(input logic pred, input logic actual,
                                      input logic npc_match);
    redir_e r;
    r = REDIR_NONE;
    if (pred && !actual)
      r = REDIR_FALLTHRU;
    else if (actual && (!pred || !npc_match))
      r = REDIR_TARGET;
    return r;
  endfunction

endpackage

// File: rtl/branch_resolver_fifo.sv
// Generic synchronous FIFO with push/pop/flush; head data is read combinationally.
// Flush and reset both clear pointers and count; flush wins over a same-cycle push.
module brq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A push at full is only legal when the head leaves on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves each fetched instruction's prediction at E and issues a one-cycle redirect on mispredict.
// Define BRANCH_RESOLVER_STATS_EN to add BranchCount / MispredictCount outputs.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PushF,
  input  logic [WORD_SIZE-1:0] CurrentPC,
  input  logic [WORD_SIZE-1:0] PCPlus4F,
  input  logic                 TakingBranch,
  input  logic [WORD_SIZE-1:0] NextInstruction,
  input  logic                 PopE,
  input  logic                 BranchE,
  input  logic                 ZeroE,
  input  logic [WORD_SIZE-1:0] PCTargetE,
  output logic [WORD_SIZE-1:0] ResolvedPC,
  output logic                 resetBranch,
  output logic [WORD_SIZE-1:0] SavedPC,
  output logic                 StallF,
`ifdef BRANCH_RESOLVER_STATS_EN
  output logic [31:0]          BranchCount,
  output logic [31:0]          MispredictCount,
`endif
  output logic                 Underflow
);

  logic [BRQ_ENTRY_W-1:0] q_wdata;
  logic [BRQ_ENTRY_W-1:0] q_rdata;
  logic [PTR_W:0]         q_count;
  logic                   q_full;
  logic                   q_empty;
  logic                   q_push;
  logic                   pop_valid;
  logic                   actual_taken;
  redir_e                 redir;
  logic                   mispredict;

  logic                   reset_branch_q, reset_branch_d;
  logic [WORD_SIZE-1:0]   saved_pc_q, saved_pc_d;
  logic                   underflow_q, underflow_d;

  logic [WORD_SIZE-1:0]   head_pc;
  logic [WORD_SIZE-1:0]   head_pc4;
  logic                   head_pred;
  logic [WORD_SIZE-1:0]   head_npc;

  assign q_wdata   = {CurrentPC, PCPlus4F, TakingBranch, NextInstruction};
  assign head_pc   = q_rdata[BRQ_PC  +: WORD_SIZE];
  assign head_pc4  = q_rdata[BRQ_PC4 +: WORD_SIZE];
  assign head_pred = q_rdata[BRQ_PRED];
  assign head_npc  = q_rdata[BRQ_NPC +: WORD_SIZE];

  // Fetch is still on the wrong path during the redirect cycle.
  assign q_push       = PushF & ~reset_branch_q;
  assign pop_valid    = PopE & ~q_empty;
  assign actual_taken = BranchE & ZeroE;
  assign redir        = classify(head_pred, actual_taken, head_npc == PCTargetE);
  assign mispredict   = pop_valid && (redir != REDIR_NONE);

  brq_fifo #(
    .WIDTH (BRQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (PopE),
    .flush (mispredict),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    reset_branch_d = mispredict;
    saved_pc_d     = saved_pc_q;
    underflow_d    = underflow_q | (PopE & q_empty);
    case (redir)
      REDIR_FALLTHRU: if (pop_valid) saved_pc_d = head_pc4;
      REDIR_TARGET:   if (pop_valid) saved_pc_d = PCTargetE;
      default:        saved_pc_d = saved_pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reset_branch_q <= 1'b0;
      saved_pc_q     <= '0;
      underflow_q    <= 1'b0;
    end else begin
      reset_branch_q <= reset_branch_d;
      saved_pc_q     <= saved_pc_d;
      underflow_q    <= underflow_d;
    end
  end

  assign ResolvedPC  = (q_count == '0) ? '0 : head_pc;
  assign StallF      = q_full & ~PopE;
  assign resetBranch = reset_branch_q;
  assign SavedPC     = saved_pc_q;
  assign Underflow   = underflow_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (pop_valid && BranchE) branch_count_d = branch_count_q + 32'd1;
    if (mispredict)           mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign BranchCount     = branch_count_q;
  assign MispredictCount = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed, table-driven bench for branch_resolver with hand-written multi-cycle corner cases.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        PushF;
  logic [31:0] CurrentPC;
  logic [31:0] PCPlus4F;
  logic        TakingBranch;
  logic [31:0] NextInstruction;
  logic        PopE;
  logic        BranchE;
  logic        ZeroE;
  logic [31:0] PCTargetE;
  logic [31:0] ResolvedPC;
  logic        resetBranch;
  logic [31:0] SavedPC;
  logic        StallF;
  logic        Underflow;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolver dut (
    .clk             (clk),
    .rst             (rst),
    .PushF           (PushF),
    .CurrentPC       (CurrentPC),
    .PCPlus4F        (PCPlus4F),
    .TakingBranch    (TakingBranch),
    .NextInstruction (NextInstruction),
    .PopE            (PopE),
    .BranchE         (BranchE),
    .ZeroE           (ZeroE),
    .PCTargetE       (PCTargetE),
    .ResolvedPC      (ResolvedPC),
    .resetBranch     (resetBranch),
    .SavedPC         (SavedPC),
    .StallF          (StallF),
`ifdef BRANCH_RESOLVER_STATS_EN
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount),
`endif
    .Underflow       (Underflow)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        push;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] npc;
    logic        pop;
    logic        br;
    logic        zero;
    logic [31:0] tgt;
    logic [31:0] exp_rpc;
    logic        exp_rb;
    logic [31:0] exp_saved;
    logic        chk_saved;
    logic        exp_stall;
    logic        exp_uf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, step, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic push, input logic [31:0] pc,
                       input logic pred, input logic [31:0] npc, input logic pop,
                       input logic br, input logic zero, input logic [31:0] tgt);
    rst             = r;
    PushF           = push;
    CurrentPC       = pc;
    PCPlus4F        = pc + 32'd4;
    TakingBranch    = pred;
    NextInstruction = pred ? npc : pc + 32'd4;
    PopE            = pop;
    BranchE         = br;
    ZeroE           = zero;
    PCTargetE       = tgt;
  endtask

  // v(push,pc,pred,npc, pop,br,zero,tgt, exp_rpc, exp_rb, exp_saved, chk_saved, exp_stall, exp_uf)
  task automatic v(input logic push, input logic [31:0] pc, input logic pred,
                   input logic [31:0] npc, input logic pop, input logic br,
                   input logic zero, input logic [31:0] tgt, input logic [31:0] exp_rpc,
                   input logic exp_rb, input logic [31:0] exp_saved, input logic chk_saved,
                   input logic exp_stall, input logic exp_uf);
    vec_t e;
    e.rst = 1'b0; e.push = push; e.pc = pc; e.pred = pred; e.npc = npc;
    e.pop = pop; e.br = br; e.zero = zero; e.tgt = tgt;
    e.exp_rpc = exp_rpc; e.exp_rb = exp_rb; e.exp_saved = exp_saved;
    e.chk_saved = chk_saved; e.exp_stall = exp_stall; e.exp_uf = exp_uf;
    vecs.push_back(e);
  endtask

  task automatic idle_check(input int step, input logic [31:0] rpc, input logic rb,
                            input logic [31:0] saved, input logic chk_saved,
                            input logic stall, input logic uf);
    check("resolved_pc", step, ResolvedPC, rpc);
    check("reset_branch", step, {31'd0, resetBranch}, {31'd0, rb});
    if (chk_saved) check("saved_pc", step, SavedPC, saved);
    check("stall_f", step, {31'd0, StallF}, {31'd0, stall});
    check("underflow", step, {31'd0, Underflow}, {31'd0, uf});
  endtask

  initial begin
    // Expectations are observed with the row's inputs applied, before its clock edge.
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   0, 32'h0,   1, 0, 0); // reset state
    // predicted not-taken, actually taken
    v(1, 32'h10, 0, 0, 0, 0, 0, 0,      32'h0,   0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 1, 1, 32'h40, 32'h10,  0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   1, 32'h40,  1, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   0, 0,       0, 0, 0);
    // predicted taken, actually not-taken; younger entries flushed
    v(1, 32'h20, 1, 32'h80, 0, 0, 0, 0, 32'h0,   0, 0,       0, 0, 0);
    v(1, 32'h80, 0, 0, 0, 0, 0, 0,      32'h20,  0, 0,       0, 0, 0);
    v(1, 32'h84, 0, 0, 0, 0, 0, 0,      32'h20,  0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 1, 0, 32'h99, 32'h20,  0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   1, 32'h24,  1, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   0, 0,       0, 0, 0);
    // fill to full, drop push at full, pop+push at full, drain through wrapped pointers
    v(1, 32'h100, 0, 0, 0, 0, 0, 0,     32'h0,   0, 0,       0, 0, 0);
    v(1, 32'h104, 0, 0, 0, 0, 0, 0,     32'h100, 0, 0,       0, 0, 0);
    v(1, 32'h108, 0, 0, 0, 0, 0, 0,     32'h100, 0, 0,       0, 0, 0);
    v(1, 32'h10c, 0, 0, 0, 0, 0, 0,     32'h100, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h100, 0, 0,       0, 1, 0);
    v(1, 32'h110, 0, 0, 0, 0, 0, 0,     32'h100, 0, 0,       0, 1, 0);
    v(1, 32'h114, 0, 0, 1, 0, 0, 0,     32'h100, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h104, 0, 0,       0, 1, 0);
    v(0, 0, 0, 0,      1, 0, 0, 0,      32'h104, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 0, 0, 0,      32'h108, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 0, 0, 0,      32'h10c, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 0, 0, 0,      32'h114, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   0, 0,       0, 0, 0);
    // taken with wrong target
    v(1, 32'h200, 1, 32'h100, 0, 0, 0, 0, 32'h0, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 1, 1, 32'h104, 32'h200, 0, 0,      0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   1, 32'h104, 1, 0, 0);
    // taken with correct target: no redirect
    v(1, 32'h210, 1, 32'h300, 0, 0, 0, 0, 32'h0, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 1, 1, 32'h300, 32'h210, 0, 0,      0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   0, 0,       0, 0, 0);
    // predicted taken on a non-branch, push during redirect, then pop on empty
    v(1, 32'h400, 1, 32'h500, 0, 0, 0, 0, 32'h0, 0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 0, 1, 32'h500, 32'h400, 0, 0,      0, 0, 0);
    v(1, 32'h999, 0, 0, 0, 0, 0, 0,     32'h0,   1, 32'h404, 1, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      1, 0, 0, 0,      32'h0,   0, 0,       0, 0, 0);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h0,   0, 0,       0, 0, 1);
    v(1, 32'h600, 0, 0, 0, 0, 0, 0,     32'h0,   0, 0,       0, 0, 1);
    v(0, 0, 0, 0,      0, 0, 0, 0,      32'h600, 0, 0,       0, 0, 1);

    // reset block
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].push, vecs[i].pc, vecs[i].pred, vecs[i].npc,
            vecs[i].pop, vecs[i].br, vecs[i].zero, vecs[i].tgt);
      #1;
      idle_check(i, vecs[i].exp_rpc, vecs[i].exp_rb, vecs[i].exp_saved,
                 vecs[i].chk_saved, vecs[i].exp_stall, vecs[i].exp_uf);
    end

    // Mid-operation reset with 3 entries and a mispredicting pop pending
    @(negedge clk); drive(0, 1, 32'h700, 1, 32'h800, 0, 0, 0, 0);
    @(negedge clk); drive(0, 1, 32'h704, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 1, 32'h708, 0, 0, 1, 1, 1, 32'h900);
    #1;
    check("pre_reset_resolved_pc", 100, ResolvedPC, 32'h600);
    check("pre_reset_underflow", 100, {31'd0, Underflow}, 32'd1);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("branch_count", 100, BranchCount, 32'd4);
    check("mispredict_count", 100, MispredictCount, 32'd4);
`endif
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    idle_check(101, 32'h0, 0, 32'h0, 1, 0, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("branch_count_rst", 101, BranchCount, 32'd0);
    check("mispredict_count_rst", 101, MispredictCount, 32'd0);
`endif

    // PopE during the redirect cycle counts as a pop on empty
    @(negedge clk); drive(0, 1, 32'h30, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 1, 1, 32'h50);
    #1;
    check("seq_resolved_pc", 102, ResolvedPC, 32'h30);
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    idle_check(103, 32'h0, 1, 32'h50, 1, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    idle_check(104, 32'h0, 0, 32'h0, 0, 0, 1);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("branch_count_end", 104, BranchCount, 32'd1);
    check("mispredict_count_end", 104, MispredictCount, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
